// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  // Handshake: the master raises dmem_req with we/addr/wdata/be stable and keeps all of them
  // unchanged until the slave answers with a one-cycle dmem_ack. dmem_rdata is only meaningful
  // in that ack cycle. The master drops dmem_req on the ack edge. An ack with no request is ignored.
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: drives the req/ack data bus, aligns and extends loads, flags errors.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              mem_wEn,
  input  logic              mem_rEn,
  input  logic              load_extend_sign,
  input  logic [1:0]        MemSize,
  input  logic [ADDR_W-1:0] ALU_result,
  input  logic [31:0]       Rdata2,
  output logic              stall,
  output logic              valid_out,
  output logic [31:0]       DataWord,
  output logic              mem_err,
  mem_access_unit_if.master dmem,
  output logic              state_dbg
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state, state_n;

  logic       access, bad;
  logic [1:0] lane;
  logic       start, done, abort, quick_resp;
  logic       timeout;

  logic       we_q, sign_q;
  logic [1:0] size_q, lane_q;

  logic [31:0] wdata_n;
  logic [3:0]  be_n;
  logic [31:0] shifted, load_ext;

  assign lane   = ALU_result[1:0];
  assign access = valid_in & (mem_wEn | mem_rEn);
  assign bad    = (MemSize == 2'b11) |
                  ((MemSize == 2'b01) & lane[0]) |
                  ((MemSize == 2'b10) & (lane != 2'b00));

  assign state_dbg = (state == REQ);

  // Store data is replicated across lanes so the memory only needs the byte enables.
  always_comb begin
    wdata_n = Rdata2;
    be_n    = 4'b1111;
    case (MemSize)
      2'b00: begin
        wdata_n = {4{Rdata2[7:0]}};
        be_n    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata_n = {2{Rdata2[15:0]}};
        be_n    = 4'b0011 << lane;
      end
      default: begin
        wdata_n = Rdata2;
        be_n    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted  = dmem.dmem_rdata >> {lane_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;

  // to_cnt holds the number of REQ cycles already spent, so the current cycle is to_cnt+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (start) begin
      to_cnt <= '0;
    end else if ((state == REQ) && !dmem.dmem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == REQ) && ((int'(to_cnt) + 1) >= TIMEOUT_CYC);
`else
  // Without the timeout the bus waits indefinitely and TIMEOUT_CYC has no effect.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    quick_resp = 1'b0;
    case (state)
      IDLE: begin
        if (access && !bad) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_n = REQ;
        end else if (valid_in) begin
          quick_resp = 1'b1;
        end
      end
      REQ: begin
        stall = !dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          stall   = 1'b0;
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q            <= 1'b0;
      sign_q          <= 1'b0;
      size_q          <= 2'b00;
      lane_q          <= 2'b00;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      valid_out       <= 1'b0;
      mem_err         <= 1'b0;
      DataWord        <= '0;
    end else begin
      valid_out <= 1'b0;
      mem_err   <= 1'b0;
      if (start) begin
        we_q            <= mem_wEn;
        sign_q          <= load_extend_sign;
        size_q          <= MemSize;
        lane_q          <= lane;
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= mem_wEn;
        dmem.dmem_addr  <= {ALU_result[ADDR_W-1:2], 2'b00};
        dmem.dmem_wdata <= wdata_n;
        dmem.dmem_be    <= mem_wEn ? be_n : 4'b0000;
      end
      // Non-memory instructions and rejected accesses answer without touching the bus.
      if (quick_resp) begin
        valid_out <= 1'b1;
        mem_err   <= access;
        DataWord  <= '0;
      end
      if (done) begin
        dmem.dmem_req <= 1'b0;
        valid_out     <= 1'b1;
        DataWord      <= we_q ? 32'h0 : load_ext;
      end
      if (abort) begin
        dmem.dmem_req <= 1'b0;
        valid_out     <= 1'b1;
        mem_err       <= 1'b1;
        DataWord      <= '0;
      end
    end
  end

endmodule
